// File: rtl/key_matrix_model.sv
// ---------------------------------------------------------------------------
// key_matrix_model
//
// Passive 4x4 membrane-keypad emulator. It sits at the far end of a
// row-scan / column-sense keypad interface. On command it presses one key
// with pseudo-random contact chatter on make and on break. It then holds the
// key closed for the requested time and releases it. A quiet gap follows
// before the next command is taken.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous, active-high reset
//   i_key_row     scan rows from the scanner, active-low (bit r low = row r driven)
//   o_key_col     column sense back to the scanner, active-low, idle 4'hF
//   i_cmd_vld     press request valid
//   i_cmd_key     key index: row = [3:2], col = [1:0]
//   i_cmd_hold    stable-closed cycles (0 behaves as 1)
//   i_cmd_abort   force an immediate release while a press is in progress
//   o_cmd_rdy     high while idle, i.e. ready to accept a command
//   o_press_done  one-cycle pulse in the first idle cycle after a press
//   o_contact     current internal switch state, 1 = closed
// ---------------------------------------------------------------------------
module key_matrix_model #(
  parameter int unsigned BOUNCE_CYC = 200,
  parameter int unsigned GAP_CYC    = 50,
  parameter int unsigned HOLD_W     = 16,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_key_row,
  output logic [3:0]        o_key_col,
  input  logic              i_cmd_vld,
  input  logic [3:0]        i_cmd_key,
  input  logic [HOLD_W-1:0] i_cmd_hold,
  input  logic              i_cmd_abort,
  output logic              o_cmd_rdy,
  output logic              o_press_done,
  output logic              o_contact
);

  // One shared down-counter times every phase. It must be wide enough for
  // the largest of the bounce length, the gap length and the hold field.
  localparam int BOUNCE_W = $clog2(BOUNCE_CYC + 1);
  localparam int GAP_W    = $clog2(GAP_CYC + 1);
  localparam int BG_W     = (BOUNCE_W > GAP_W) ? BOUNCE_W : GAP_W;
  localparam int CNT_W    = (BG_W > int'(HOLD_W)) ? BG_W : int'(HOLD_W);

  localparam logic [CNT_W-1:0] BOUNCE_LEN = CNT_W'(BOUNCE_CYC);
  localparam logic [CNT_W-1:0] GAP_LEN    = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               HAS_BOUNCE = (BOUNCE_CYC != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BON,
    ST_HOLD,
    ST_BOFF,
    ST_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_contact;
  logic                w_contact_nxt;
  logic [7:0]          r_lfsr;
  logic [7:0]          w_lfsr_nxt;
  logic [7:0]          w_lfsr_step;
  logic [3:0]          r_key;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_accept;
  logic                w_cnt_last;
  logic [HOLD_W-1:0]   w_hold_eff;
  logic [3:0]          w_key_col;

  assign o_cmd_rdy    = (r_state == ST_IDLE);
  assign o_press_done = r_done;
  assign o_contact    = r_contact;

  assign w_accept   = i_cmd_vld && (r_state == ST_IDLE);
  assign w_cnt_last = (r_cnt == CNT_ONE);
  assign w_hold_eff = (i_cmd_hold == '0) ? HOLD_W'(1) : i_cmd_hold;

  // Fibonacci LFSR, taps 8,6,5,4. A non-zero seed can never reach the
  // all-zero lock-up state, so it needs no zero guard.
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // The switch only reaches the column lines when the key's own row is being
  // driven low. Other rows do not matter, so a single closed key behaves like
  // a real membrane.
  always_comb begin
    w_key_col = 4'hF;
    if (r_contact && !i_key_row[r_key[3:2]]) begin
      w_key_col[r_key[1:0]] = 1'b0;
    end
  end

  assign o_key_col = w_key_col;

  // Next-state logic. Each transition loads the counter with the length of
  // the phase being entered. It also sets the contact value for that phase's
  // first cycle, so o_contact changes on the edge that enters the phase.
  // Bounce cycles take the LFSR's low bit and step the LFSR once per cycle.
  // The LFSR stays frozen outside bounce, which makes the chatter sequence
  // a deterministic function of everything pressed since reset.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_contact_nxt = r_contact;
    w_lfsr_nxt    = r_lfsr;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_contact_nxt = 1'b0;
        if (w_accept) begin
          if (HAS_BOUNCE) begin
            w_state_nxt   = ST_BON;
            w_cnt_nxt     = BOUNCE_LEN;
            w_contact_nxt = r_lfsr[0];
            w_lfsr_nxt    = w_lfsr_step;
          end else begin
            w_state_nxt   = ST_HOLD;
            w_cnt_nxt     = CNT_W'(w_hold_eff);
            w_contact_nxt = 1'b1;
          end
        end
      end

      ST_BON: begin
        if (i_cmd_abort) begin
          w_state_nxt   = ST_GAP;
          w_cnt_nxt     = GAP_LEN;
          w_contact_nxt = 1'b0;
        end else if (w_cnt_last) begin
          w_state_nxt   = ST_HOLD;
          w_cnt_nxt     = CNT_W'(r_hold);
          w_contact_nxt = 1'b1;
        end else begin
          w_cnt_nxt     = r_cnt - CNT_ONE;
          w_contact_nxt = r_lfsr[0];
          w_lfsr_nxt    = w_lfsr_step;
        end
      end

      ST_HOLD: begin
        if (i_cmd_abort) begin
          w_state_nxt   = ST_GAP;
          w_cnt_nxt     = GAP_LEN;
          w_contact_nxt = 1'b0;
        end else if (w_cnt_last) begin
          if (HAS_BOUNCE) begin
            w_state_nxt   = ST_BOFF;
            w_cnt_nxt     = BOUNCE_LEN;
            w_contact_nxt = r_lfsr[0];
            w_lfsr_nxt    = w_lfsr_step;
          end else begin
            w_state_nxt   = ST_GAP;
            w_cnt_nxt     = GAP_LEN;
            w_contact_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt     = r_cnt - CNT_ONE;
          w_contact_nxt = 1'b1;
        end
      end

      ST_BOFF: begin
        if (i_cmd_abort || w_cnt_last) begin
          w_state_nxt   = ST_GAP;
          w_cnt_nxt     = GAP_LEN;
          w_contact_nxt = 1'b0;
        end else begin
          w_cnt_nxt     = r_cnt - CNT_ONE;
          w_contact_nxt = r_lfsr[0];
          w_lfsr_nxt    = w_lfsr_step;
        end
      end

      ST_GAP: begin
        w_contact_nxt = 1'b0;
        if (w_cnt_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_cnt_nxt     = '0;
        w_contact_nxt = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers. The key and hold values are captured only on the
  // accept edge, so a request that arrives while a press is in progress has
  // no effect on it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_contact <= 1'b0;
      r_lfsr    <= LFSR_SEED;
      r_key     <= 4'h0;
      r_hold    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_contact <= w_contact_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_done    <= w_done_nxt;
      if (w_accept) begin
        r_key  <= i_cmd_key;
        r_hold <= w_hold_eff;
      end
    end
  end

endmodule
